lzrw_decomp_sequencer: RTL and testbench
========================================

# lzrw_decomp_sequencer

Sequencer that walks an LZRW1-format compressed buffer in a synchronous byte RAM and feeds the decompressor one item at a time. It reads each 16-bit control word, then the literal (1-byte) or copy (2-byte) items that follow it, and presents them on the decompressor's `data_in` / `control_word_in` / `data_in_valid` inputs. It holds each item while `decompressor_busy` is high. It sits between the compressed-data RAM and the decompressor, in place of ad-hoc pointer logic in the combined top.

## Interface
Parameters:
- ADDR_W, 12: compressed RAM address width; byte addresses wrap modulo 2^ADDR_W.
- CNT_W, 13: width of the item counter.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of the first control word; captured on start.
- item_count  in  CNT_W  number of items to issue; captured on start.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM byte address; rd_data is valid the cycle after rd_en.
- rd_data  in  8  RAM read data.
- data_in  out  16  item to the decompressor: literal = {8'h00, b0}; copy = {b0, b1}.
- control_word_in  out  1  1 = copy item, 0 = literal.
- data_in_valid  out  1  item valid.
- decompressor_busy  in  1  when high, the item is held.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last item is accepted.

## Operation
- Buffer layout: a 2-byte control word (low byte first), then up to 16 items, then the next control word. Bit i of the control word (LSB first) gives the type of item i.
- States:
  - IDLE: on start, latch base_addr into ptr and item_count into remaining; go to CW_LO. If item_count == 0, go straight to DONE with no RAM reads.
  - CW_LO: rd_en, rd_addr = ptr, ptr+1 → CW_HI.
  - CW_HI: capture low byte; rd_en, rd_addr = ptr, ptr+1 → CW_CAP.
  - CW_CAP: capture high byte; bit_idx = 0 → B0.
  - B0: rd_en, rd_addr = ptr, ptr+1 → B0_CAP.
  - B0_CAP: capture b0. If cw[bit_idx] = 1: rd_en, rd_addr = ptr, ptr+1 → B1_CAP. Otherwise → ISSUE.
  - B1_CAP: capture b1 → ISSUE.
  - ISSUE: data_in_valid = 1; data_in and control_word_in are stable. An item is accepted in a cycle where data_in_valid && !decompressor_busy. On accept, remaining−1:
    - remaining becomes 0 → DONE.
    - else bit_idx == 15 → CW_LO.
    - else bit_idx+1 → B0.
  - DONE: done = 1 for one cycle → IDLE.
- rd_en and rd_addr decode from registered state and ptr only.
- data_in and control_word_in are 0 whenever data_in_valid = 0.
- start outside IDLE is ignored.
- ptr wraps from 2^ADDR_W−1 to 0 silently.
- An item count that ends mid-control-word leaves the unused control bits ignored.

## Timing
- Reset (asynchronous): state IDLE; ptr, remaining, bit_idx, control word and byte registers cleared. All outputs are 0.
- Start is sampled at edge 0. First item:
  - literal: data_in_valid high in cycle 6.
  - copy: data_in_valid high in cycle 7.
- Accept in cycle n, next item in the same control group:
  - literal: data_in_valid in n+3.
  - copy: data_in_valid in n+4.
  - Add 3 cycles when a new control word is fetched.
- Last item accepted in cycle n → done in cycle n+1; busy falls in cycle n+2.
- decompressor_busy held high indefinitely: data_in_valid and data_in hold, and no reads are issued.
- Reset asserted mid-operation returns to IDLE immediately. No done pulse is produced.

## Configuration
- LZRW_SEQ_ABORT_EN defined:
  - Adds input `abort` (1 bit).
  - abort high in any non-IDLE state forces IDLE at the next edge.
  - data_in_valid drops that next cycle; done is not pulsed; any in-flight rd_data is discarded.
  - abort has priority over accept and over the DONE transition.
- Not defined: no abort port; a sequence always runs to done or reset.

## Test plan
- RAM at 0: 0x00,0x00 (cw=0), 'A','B','C'; item_count=3, decompressor_busy=0 → items 0x0041, 0x0042, 0x0043 in cycles 6, 9, 12; done in cycle 13.
- cw=0x0001, bytes 0x12,0x34, then 'x'; item_count=2 → item0 = 0x1234 with control_word_in=1 in cycle 7; item1 = 0x0078 with control_word_in=0 in cycle 10.
- 17 literal items with the second control word at byte 18 → rd_addr sequence shows 18,19 read between item 16 and item 17; 17 accepts, then one done pulse.
- decompressor_busy high for 5 cycles during the first ISSUE → data_in_valid and data_in unchanged over all 5 cycles; rd_en stays 0; accept on the first busy-low cycle.
- base_addr = 2^ADDR_W−2, cw=0 then 'Q' → reads at 4094, 4095, 0; item 0x0051. Also: item_count=0 → done in cycle 1 with no rd_en.
- Reset pulsed in ISSUE → busy, data_in_valid and done all 0 immediately. Under LZRW_SEQ_ABORT_EN: abort in B0_CAP → IDLE next cycle, no done; a following start runs normally.

Source files
------------

// File: rtl/lzrw_decomp_sequencer.sv
// Walks an LZRW1 compressed buffer in a synchronous byte RAM and issues one item at a time to the decompressor.
// Optional abort input is enabled with `define LZRW_SEQ_ABORT_EN.
module lzrw_decomp_sequencer #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  item_count,
`ifdef LZRW_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [15:0]       data_in,
  output logic              control_word_in,
  output logic              data_in_valid,
  input  logic              decompressor_busy,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, CW_LO, CW_HI, CW_CAP, B0, B0_CAP, B1_CAP, ISSUE, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [CNT_W-1:0]  remaining_r;
  logic [3:0]        bit_idx_r;
  logic [15:0]       cw_r;
  logic [7:0]        b0_r, b1_r;
  logic              rd_en_s, load_s, accept_s, abort_s, is_copy_s;

`ifdef LZRW_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign is_copy_s = cw_r[bit_idx_r];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and per-state strobes
  always_comb begin
    state_s  = state_r;
    rd_en_s  = 1'b0;
    load_s   = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = (item_count == CNT_ZERO) ? DONE : CW_LO;
        end else begin
          state_s = IDLE;
        end
      end
      CW_LO: begin
        rd_en_s = 1'b1;
        state_s = CW_HI;
      end
      CW_HI: begin
        rd_en_s = 1'b1;
        state_s = CW_CAP;
      end
      CW_CAP: state_s = B0;
      B0: begin
        rd_en_s = 1'b1;
        state_s = B0_CAP;
      end
      B0_CAP: begin
        if (is_copy_s) begin
          rd_en_s = 1'b1;
          state_s = B1_CAP;
        end else begin
          state_s = ISSUE;
        end
      end
      B1_CAP: state_s = ISSUE;
      ISSUE: begin
        if (!decompressor_busy) begin
          accept_s = 1'b1;
          if (remaining_r == CNT_ONE) begin
            state_s = DONE;
          end else if (bit_idx_r == 4'd15) begin
            state_s = CW_LO;
          end else begin
            state_s = B0;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    // Abort wins over accept and over the DONE -> IDLE pulse path
    if (abort_s && (state_r != IDLE)) begin
      state_s  = IDLE;
      accept_s = 1'b0;
    end else begin
      accept_s = accept_s;
    end
  end

  // Pointer, counters, control word and item byte registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r       <= {ADDR_W{1'b0}};
      remaining_r <= CNT_ZERO;
      bit_idx_r   <= 4'd0;
      cw_r        <= 16'h0000;
      b0_r        <= 8'h00;
      b1_r        <= 8'h00;
    end else begin
      if (load_s) begin
        ptr_r       <= base_addr;
        remaining_r <= item_count;
      end else begin
        if (rd_en_s) ptr_r <= ptr_r + ADDR_ONE;
        if (accept_s) remaining_r <= remaining_r - CNT_ONE;
      end
      if (state_r == CW_HI) cw_r[7:0]  <= rd_data;
      if (state_r == CW_CAP) begin
        cw_r[15:8] <= rd_data;
        bit_idx_r  <= 4'd0;
      end else if (accept_s) begin
        bit_idx_r  <= bit_idx_r + 4'd1;
      end
      if (state_r == B0_CAP) b0_r <= rd_data;
      if (state_r == B1_CAP) b1_r <= rd_data;
    end
  end

  assign rd_en           = rd_en_s;
  assign rd_addr         = rd_en_s ? ptr_r : {ADDR_W{1'b0}};
  assign data_in_valid   = (state_r == ISSUE);
  assign control_word_in = data_in_valid & is_copy_s;
  assign data_in         = !data_in_valid ? 16'h0000 :
                           (is_copy_s ? {b0_r, b1_r} : {8'h00, b0_r});
  assign busy            = (state_r != IDLE);
  assign done            = (state_r == DONE);

endmodule

// File: tb/tb_lzrw_decomp_sequencer.sv
// Directed self-checking bench for lzrw_decomp_sequencer with a synchronous byte RAM model.
module tb_lzrw_decomp_sequencer;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 13;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  item_count = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = 8'h00;
  logic [15:0]       data_in;
  logic              control_word_in, data_in_valid, busy, done;
  logic              decompressor_busy = 1'b0;
`ifdef LZRW_SEQ_ABORT_EN
  logic              abort = 1'b0;
`endif

  logic [7:0] mem [0:4095];
  int edge_cnt = 0;
  int t0 = 0;
  int n_checks = 0;
  int n_fail = 0;
  int it_data[$];
  int it_cw[$];
  int it_cyc[$];
  int done_cyc[$];
  int addr_q[$];

  lzrw_decomp_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .item_count(item_count),
`ifdef LZRW_SEQ_ABORT_EN
    .abort(abort),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .data_in(data_in),
    .control_word_in(control_word_in), .data_in_valid(data_in_valid),
    .decompressor_busy(decompressor_busy), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    edge_cnt <= edge_cnt + 1;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Cycle k is the clock period following edge k-1, edge 0 sampling start
  always @(negedge clock) begin
    if (data_in_valid && !decompressor_busy) begin
      it_data.push_back(int'(data_in));
      it_cw.push_back(int'(control_word_in));
      it_cyc.push_back(edge_cnt - t0 + 1);
    end
    if (done) done_cyc.push_back(edge_cnt - t0 + 1);
    if (rd_en) addr_q.push_back(int'(rd_addr));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hdead;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  endtask

  task automatic start_seq(input int base, input int cnt);
    @(negedge clock);
    it_data.delete(); it_cw.delete(); it_cyc.delete();
    done_cyc.delete(); addr_q.delete();
    base_addr  = ADDR_W'(base);
    item_count = CNT_W'(cnt);
    start      = 1'b1;
    t0         = edge_cnt + 1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!done && k < budget);
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_in_done"}, busy, 1);
    @(negedge clock);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic load_abc();
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'h00;
    mem[2] = 8'h41; mem[3] = 8'h42; mem[4] = 8'h43;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_valid", data_in_valid, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_data", data_in, 0);
    check("rst_addr", rd_addr, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // Three literals
    load_abc();
    start_seq(0, 3);
    wait_done("lit3", 40);
    check("lit3_n", it_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lit3_data%0d", i), qget(it_data, i), 32'h41 + i);
      check($sformatf("lit3_cw%0d", i), qget(it_cw, i), 0);
      check($sformatf("lit3_cyc%0d", i), qget(it_cyc, i), 6 + 3 * i);
    end
    check("lit3_done_cyc", qget(done_cyc, 0), 13);
    check("lit3_done_n", done_cyc.size(), 1);

    // Copy then literal
    clear_mem();
    mem[16] = 8'h01; mem[17] = 8'h00; mem[18] = 8'h12; mem[19] = 8'h34; mem[20] = 8'h78;
    start_seq(16, 2);
    wait_done("copy", 40);
    check("copy_d0", qget(it_data, 0), 32'h1234);
    check("copy_cw0", qget(it_cw, 0), 1);
    check("copy_c0", qget(it_cyc, 0), 7);
    check("copy_d1", qget(it_data, 1), 32'h0078);
    check("copy_cw1", qget(it_cw, 1), 0);
    check("copy_c1", qget(it_cyc, 1), 10);
    check("copy_done_cyc", qget(done_cyc, 0), 11);

    // 17 literals across two control words
    clear_mem();
    for (int i = 0; i < 16; i++) mem[2 + i] = 8'h60 + 8'(i);
    mem[20] = 8'h70;
    start_seq(0, 17);
    wait_done("cw2", 200);
    check("cw2_n", it_data.size(), 17);
    check("cw2_d15", qget(it_data, 15), 32'h6f);
    check("cw2_c15", qget(it_cyc, 15), 51);
    check("cw2_d16", qget(it_data, 16), 32'h70);
    check("cw2_c16", qget(it_cyc, 16), 57);
    check("cw2_nrd", addr_q.size(), 21);
    check("cw2_a18", qget(addr_q, 18), 18);
    check("cw2_a19", qget(addr_q, 19), 19);
    check("cw2_a20", qget(addr_q, 20), 20);
    check("cw2_done_n", done_cyc.size(), 1);

    // Hold the first item for five cycles of decompressor_busy
    load_abc();
    decompressor_busy = 1'b1;
    start_seq(0, 3);
    begin
      int k;
      k = 0;
      do begin
        @(negedge clock);
        k++;
      end while (!data_in_valid && k < 20);
    end
    check("hold_first_cyc", edge_cnt - t0 + 1, 6);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clock);
      check($sformatf("hold_valid%0d", j), data_in_valid, 1);
      check($sformatf("hold_data%0d", j), data_in, 16'h0041);
      check($sformatf("hold_rd%0d", j), rd_en, 0);
    end
    @(posedge clock);
    #1 decompressor_busy = 1'b0;
    wait_done("hold", 40);
    check("hold_c0", qget(it_cyc, 0), 11);
    check("hold_d2", qget(it_data, 2), 32'h43);
    check("hold_c2", qget(it_cyc, 2), 17);
    check("hold_done_cyc", qget(done_cyc, 0), 18);

    // Address wrap
    clear_mem();
    mem[4094] = 8'h00; mem[4095] = 8'h00; mem[0] = 8'h51;
    start_seq(4094, 1);
    wait_done("wrap", 40);
    check("wrap_a0", qget(addr_q, 0), 4094);
    check("wrap_a1", qget(addr_q, 1), 4095);
    check("wrap_a2", qget(addr_q, 2), 0);
    check("wrap_d0", qget(it_data, 0), 32'h51);
    check("wrap_c0", qget(it_cyc, 0), 6);

    // Zero item count
    start_seq(0, 0);
    wait_done("zero", 10);
    check("zero_done_cyc", qget(done_cyc, 0), 1);
    check("zero_nrd", addr_q.size(), 0);

    // Reset while an item is on offer
    load_abc();
    start_seq(0, 3);
    begin
      int k;
      k = 0;
      do begin
        @(negedge clock);
        k++;
      end while (!data_in_valid && k < 20);
    end
    check("rstmid_valid_before", data_in_valid, 1);
    #1 reset = 1'b1;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", data_in_valid, 0);
    check("rstmid_done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("rstmid_no_done", done_cyc.size(), 0);

`ifdef LZRW_SEQ_ABORT_EN
    // Abort in B0_CAP of a copy item
    clear_mem();
    mem[16] = 8'h01; mem[17] = 8'h00; mem[18] = 8'h12; mem[19] = 8'h34; mem[20] = 8'h78;
    start_seq(16, 2);
    repeat (5) @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", data_in_valid, 0);
    repeat (10) @(negedge clock);
    check("abort_no_done", done_cyc.size(), 0);
    check("abort_no_item", it_data.size(), 0);
`endif

    // Normal run after the interruption
    load_abc();
    start_seq(0, 3);
    wait_done("again", 40);
    check("again_n", it_data.size(), 3);
    check("again_c2", qget(it_cyc, 2), 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
